// File: rtl/instr_load_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding,
// error codes and the byte-index type used by the word assembler.
package instr_load_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LEN_LO = 3'd1;
    localparam logic [2:0] ST_LEN_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CSUM   = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int BYTE_IDX_W = 2;
    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/instr_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words and emits a one-cycle
// word_valid pulse the cycle after the fourth byte of each word arrives.
module instr_word_assembler
    import instr_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_last,
    output logic        word_valid,
    output logic [31:0] word
);

    byte_idx_t   byte_cnt;
    logic [31:0] shift_reg;

    assign word_last = byte_valid && (byte_cnt == byte_idx_t'(3));

    // The finished word is latched separately so that byte0 of the next word,
    // arriving in the same cycle as the write strobe, cannot corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            shift_reg  <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                byte_cnt  <= byte_cnt + 1'b1;
                shift_reg <= {byte_data, shift_reg[31:8]};
                if (word_last) begin
                    word_valid <= 1'b1;
                    word       <= {byte_data, shift_reg[31:8]};
                end
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Receives a length-prefixed, XOR-checksummed program image over a byte link and
// writes it word by word into instruction RAM while holding the CPU stalled.
module instr_mem_loader
    import instr_load_pkg::*;
#(
    parameter int          DEPTH          = 64,
    parameter logic [31:0] BASE_ADDR      = 32'd0,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code
);

    logic [2:0]  state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [7:0]  csum;
    logic [31:0] idle_cnt;
    logic        receiving;
    logic        accept;
    logic        start_taken;
    logic        timeout_hit;
    logic        word_last;
    logic [15:0] len_next;

    assign receiving   = state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    assign in_ready    = receiving;
    assign accept      = in_valid && in_ready;
    assign start_taken = start && (state == ST_IDLE || state == ST_ERR);
    assign error       = (state == ST_ERR);
    assign len_next    = {in_data, len_lo};
    assign timeout_hit = receiving && !accept && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

    instr_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_taken),
        .byte_valid (accept && state == ST_DATA),
        .byte_data  (in_data),
        .word_last  (word_last),
        .word_valid (wr_en),
        .word       (wr_data)
    );

    // Frame sequencing: the running XOR covers every accepted byte including C,
    // so a good frame leaves csum ^ C == 0 when the checksum byte arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_lo   <= '0;
            len      <= '0;
            word_cnt <= '0;
            csum     <= '0;
            idle_cnt <= '0;
            wr_addr  <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            done <= 1'b0;
            if (start_taken) begin
                state    <= ST_LEN_LO;
                cpu_hold <= 1'b1;
                err_code <= ERR_NONE;
                csum     <= '0;
                idle_cnt <= '0;
                word_cnt <= '0;
                len      <= '0;
                len_lo   <= '0;
            end else if (timeout_hit) begin
                state    <= ST_ERR;
                err_code <= ERR_TIMEOUT;
            end else if (receiving) begin
                if (accept) begin
                    idle_cnt <= '0;
                    csum     <= csum ^ in_data;
                    case (state)
                        ST_LEN_LO: begin
                            len_lo <= in_data;
                            state  <= ST_LEN_HI;
                        end
                        ST_LEN_HI: begin
                            len <= len_next;
                            if (32'(len_next) > 32'(DEPTH)) begin
                                state    <= ST_ERR;
                                err_code <= ERR_LEN;
                            end else if (len_next == 16'd0) begin
                                state <= ST_CSUM;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            if (word_last) begin
                                word_cnt <= word_cnt + 16'd1;
                                wr_addr  <= BASE_ADDR + 32'(word_cnt);
                                if (word_cnt + 16'd1 == len) begin
                                    state <= ST_CSUM;
                                end
                            end
                        end
                        ST_CSUM: begin
                            if ((csum ^ in_data) == 8'h00) begin
                                state    <= ST_IDLE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state    <= ST_ERR;
                                err_code <= ERR_CSUM;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end
        end
    end

endmodule
